// File: rtl/alu_exec_ctrl_if.sv
// Bus between alu_exec_ctrl and its environment: op issue, ALU drive/return, result drain.
// master = op source / ALU / result sink, slave = the controller.
interface alu_exec_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_S;
    logic              alu_Cin;
    logic [DATA_W-1:0] alu_d;
    logic              alu_Cout;
    logic              alu_V;
    logic              alu_Z;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              out_err;
    logic              flag_c;
    logic              flag_v;
    logic              flag_z;
    logic              busy;

    modport slave (
        input  in_valid, op, a, b, alu_d, alu_Cout, alu_V, alu_Z, out_ready,
        output in_ready, alu_a, alu_b, alu_S, alu_Cin, out_valid, result,
               out_err, flag_c, flag_v, flag_z, busy
    );

    modport master (
        output in_valid, op, a, b, alu_d, alu_Cout, alu_V, alu_Z, out_ready,
        input  in_ready, alu_a, alu_b, alu_S, alu_Cin, out_valid, result,
               out_err, flag_c, flag_v, flag_z, busy
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller in front of a 32-bit ALU; adds ADDC/SUBC, SLT(U) and iterative shifts.
// Result 1 cycle after accept (n cycles for shift by n); holds result until out_ready. ALU_EXEC_ROR_EN adds op 14 ROR.
module alu_exec_ctrl #(
    parameter int         DATA_W    = 32,
    parameter logic [2:0] FLAGS_RST = 3'b000
) (
    input logic            clk,
    input logic            rst_n,
    alu_exec_ctrl_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDC = 4'd2;
    localparam logic [3:0] OP_SUBC = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_SLL  = 4'd11;
    localparam logic [3:0] OP_SRL  = 4'd12;
    localparam logic [3:0] OP_SRA  = 4'd13;
`ifdef ALU_EXEC_ROR_EN
    localparam logic [3:0] OP_ROR  = 4'd14;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, RESP = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, sh_q, result_q;
    logic [4:0]        cnt_q;
    logic              err_q, fc_q, fv_q, fz_q;

    logic              in_rdy, accept, start_shift;
    logic [2:0]        alu_s_c;
    logic              alu_cin_c;
    logic [DATA_W-1:0] ex_res, sh_nx;
    logic              ex_err, ex_upd_cv, sh_out;
    logic              unused_alu_z;

    function automatic logic is_shift(input logic [3:0] o);
        logic s;
        s = (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
`ifdef ALU_EXEC_ROR_EN
        s = s || (o == OP_ROR);
`endif
        return s;
    endfunction

    function automatic logic is_rsvd(input logic [3:0] o);
`ifdef ALU_EXEC_ROR_EN
        return o == 4'd15;
`else
        return (o == 4'd14) || (o == 4'd15);
`endif
    endfunction

    // Zero flag is derived from the captured result, so the ALU's own Z is not needed.
    assign unused_alu_z = bus.alu_Z;

    assign accept      = bus.in_valid && in_rdy;
    assign start_shift = is_shift(bus.op) && (bus.b[4:0] != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept)                                state_d = start_shift ? SHIFT : EXEC;
                else if (state_q == RESP && bus.out_ready) state_d = IDLE;
            end
            EXEC:    state_d = RESP;
            SHIFT:   if (cnt_q == 5'd1) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rdy    = (state_q == IDLE) || (state_q == RESP && bus.out_ready);
        alu_s_c   = 3'b111;
        alu_cin_c = 1'b0;
        if (state_q == EXEC) begin
            case (op_q)
                OP_ADD:           alu_s_c = 3'b010;
                OP_SUB:           begin alu_s_c = 3'b011; alu_cin_c = 1'b1; end
                OP_ADDC:          begin alu_s_c = 3'b010; alu_cin_c = fc_q; end
                OP_SUBC:          begin alu_s_c = 3'b011; alu_cin_c = fc_q; end
                OP_XOR:           alu_s_c = 3'b000;
                OP_XNOR:          alu_s_c = 3'b001;
                OP_OR:            alu_s_c = 3'b100;
                OP_NOR:           alu_s_c = 3'b101;
                OP_AND:           alu_s_c = 3'b110;
                OP_SLT, OP_SLTU:  begin alu_s_c = 3'b011; alu_cin_c = 1'b1; end
                default:          alu_s_c = 3'b111;
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == RESP);
    assign bus.busy      = (state_q != IDLE);
    assign bus.alu_S     = alu_s_c;
    assign bus.alu_Cin   = alu_cin_c;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.result    = result_q;
    assign bus.out_err   = err_q;
    assign bus.flag_c    = fc_q;
    assign bus.flag_v    = fv_q;
    assign bus.flag_z    = fz_q;

    always_comb begin
        ex_res    = bus.alu_d;
        ex_err    = 1'b0;
        ex_upd_cv = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_ADDC, OP_SUBC: ex_upd_cv = 1'b1;
            OP_SLT: begin
                ex_res    = {{(DATA_W-1){1'b0}}, bus.alu_d[DATA_W-1] ^ bus.alu_V};
                ex_upd_cv = 1'b1;
            end
            OP_SLTU: begin
                ex_res    = {{(DATA_W-1){1'b0}}, ~bus.alu_Cout};
                ex_upd_cv = 1'b1;
            end
            default: begin
                // Zero-amount shifts reach EXEC and simply pass the operand through.
                if (is_shift(op_q)) begin
                    ex_res = a_q;
                end else if (is_rsvd(op_q)) begin
                    ex_res = '0;
                    ex_err = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        sh_nx  = sh_q;
        sh_out = 1'b0;
        case (op_q)
            OP_SLL: begin sh_nx = {sh_q[DATA_W-2:0], 1'b0};          sh_out = sh_q[DATA_W-1]; end
            OP_SRL: begin sh_nx = {1'b0, sh_q[DATA_W-1:1]};          sh_out = sh_q[0];        end
            OP_SRA: begin sh_nx = {sh_q[DATA_W-1], sh_q[DATA_W-1:1]}; sh_out = sh_q[0];        end
`ifdef ALU_EXEC_ROR_EN
            OP_ROR: begin sh_nx = {sh_q[0], sh_q[DATA_W-1:1]};       sh_out = sh_q[0];        end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            fc_q     <= FLAGS_RST[2];
            fv_q     <= FLAGS_RST[1];
            fz_q     <= FLAGS_RST[0];
        end else begin
            if (accept) begin
                op_q  <= bus.op;
                a_q   <= bus.a;
                b_q   <= bus.b;
                sh_q  <= bus.a;
                cnt_q <= bus.b[4:0];
            end
            if (state_q == EXEC) begin
                result_q <= ex_res;
                err_q    <= ex_err;
                if (ex_upd_cv) begin
                    fc_q <= bus.alu_Cout;
                    fv_q <= bus.alu_V;
                end
                if (!ex_err) fz_q <= (ex_res == '0);
            end
            if (state_q == SHIFT) begin
                sh_q  <= sh_nx;
                cnt_q <= cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_q <= sh_nx;
                    err_q    <= 1'b0;
                    fc_q     <= sh_out;
                    fz_q     <= (sh_nx == '0);
                end
            end
        end
    end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage controller directly upstream of the 32-bit carry-lookahead ALU (select S[2:0], Cin; returns d, Cout, V, Z).
- Accepts decoded ops over a valid/ready handshake, registers operands, drives the ALU, and captures the result plus the C/V/Z flags into an output register.
- Adds carry-chained ops (ADDC/SUBC), set-less-than, and iterative one-bit-per-cycle shifts, which the ALU lacks.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported because the ALU is fixed at 32 bits.
- FLAGS_RST, 3'b000, reset value of {flag_c, flag_v, flag_z}.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  op presented.
- in_ready  out  1  block can accept the op.
- op  in  4  opcode.
- a, b  in  32 each  operands; shift amount is b[4:0].
- alu_a, alu_b  out  32 each  ALU operands.
- alu_S  out  3  ALU select.
- alu_Cin  out  1  ALU carry-in.
- alu_d  in  32  ALU result.
- alu_Cout, alu_V, alu_Z  in  1 each  ALU carry-out, overflow, zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  32  registered result.
- out_err  out  1  reserved/disabled opcode was issued.
- flag_c, flag_v, flag_z  out  1 each  architectural flags.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; out_valid=0; result=0; out_err=0; flags=FLAGS_RST.
  - alu_a=0, alu_b=0, alu_S=3'b111, alu_Cin=0.
  - Any in-flight op or held result is discarded.
- Opcodes, each listed as ALU S / Cin:
  - 0 ADD: 010 / 0.
  - 1 SUB: 011 / 1.
  - 2 ADDC: 010 / flag_c.
  - 3 SUBC: 011 / flag_c.
  - 4 XOR: 000 / 0.
  - 5 XNOR: 001 / 0.
  - 6 OR: 100.
  - 7 NOR: 101.
  - 8 AND: 110.
  - 9 SLT: 011 / 1; result = {31'b0, alu_d[31]^alu_V}.
  - 10 SLTU: 011 / 1; result = {31'b0, ~alu_Cout}.
  - 11 SLL, 12 SRL, 13 SRA: iterative shifts.
  - 14 ROR: optional, see below.
  - 15: reserved.
- States:
  - IDLE: in_ready=1. An accepted ALU op goes to EXEC. An accepted shift with b[4:0]!=0 goes to SHIFT with cnt=b[4:0]. A shift with amount 0, or a reserved op, goes to EXEC.
  - EXEC (exactly 1 cycle): the registered op drives the ALU combinationally. At the next edge, result and flags are captured, state goes to RESP, and out_valid=1.
  - SHIFT: shift the internal register by 1 bit per cycle; cnt decrements. At cnt==1 the next edge captures the result, state goes to RESP. The ALU is held at S=111 during SHIFT.
  - RESP: out_valid=1; result, out_err and flags are stable until out_ready=1. in_ready = out_ready, so a new op can be accepted on the same edge the result drains. With out_ready=1 and no new op, state returns to IDLE.
- Latency from the acceptance edge E0:
  - ALU ops, zero-amount shifts and reserved ops: out_valid after E1.
  - Shift by n (n ≥ 1): out_valid after En.
  - Throughput for ALU ops is 1 per 2 cycles.
- Flag rules (all flags update at the capture edge):
  - Arithmetic ops 0–3, 9, 10: flag_c=alu_Cout, flag_v=alu_V.
  - Logic ops: flag_c and flag_v unchanged.
  - Shifts with n ≥ 1: flag_c = last bit shifted out; flag_v unchanged. Shift by 0: result=a, flag_c unchanged.
  - flag_z = (captured result == 0) for every op, including SLT. It is not taken from alu_Z.
- Reserved op: result=0, out_err=1, all flags unchanged. out_err clears on the next captured result.
- ADDC/SUBC sample flag_c as updated by the immediately preceding op, including back-to-back issue from RESP.
- in_valid with in_ready=0: the op is not consumed; the upstream must hold it.

Optional Feature:
- ALU_EXEC_ROR_EN
- Defined: op 14 = ROR, an iterative rotate right by b[4:0]. flag_c = last bit rotated into bit 31; timing is the same as SRL.
- Undefined: op 14 is reserved (result=0, out_err=1, flags unchanged); no rotate logic is synthesized.

Test Plan:
- ADD a=32'h7FFFFFFF, b=1 -> result 32'h80000000, C=0, V=1, Z=0, out_valid after 1 cycle.
- SUB a=5, b=5, then ADDC a=32'hFFFFFFFF, b=0 back-to-back with out_ready=1 -> first: result 0, C=1, Z=1; second: result 0, C=1, Z=1.
- SLT a=32'hFFFFFFFE (-2), b=3 -> result 1. SLTU with the same operands -> result 0.
- SRA a=32'h80000010, b=4 -> result 32'hF8000001, C=0, out_valid exactly 4 cycles after accept, busy high throughout. SLL by 0 -> result=a, C unchanged.
- Hold out_ready=0 for 5 cycles on an AND result -> result stable, in_ready=0, new in_valid ignored. Then assert rst_n=0 for 1 cycle while in RESP -> out_valid=0, flags=FLAGS_RST, state IDLE.
- op=15, and op=14 with the macro undefined -> result 0, out_err=1, flags unchanged. With the macro defined, ROR a=1, b=1 -> result 32'h80000000, C=1.
